// File: rtl/tennis_score_keeper_if.sv
// Score keeper bus: ball register and toss button in, scores and event pulses out.
interface tennis_score_keeper_if;
    logic [7:0] nL;
    logic       toss;
    logic [2:0] left_pts;
    logic [2:0] right_pts;
    logic [3:0] left_games;
    logic [3:0] right_games;
    logic       point_left;
    logic       point_right;
    logic       game_won;
    logic       match_over;

    modport master (
        output nL, toss,
        input  left_pts, right_pts, left_games, right_games,
        input  point_left, point_right, game_won, match_over
    );

    modport slave (
        input  nL, toss,
        output left_pts, right_pts, left_games, right_games,
        output point_left, point_right, game_won, match_over
    );
endinterface

// File: rtl/tennis_score_keeper.sv
// Tennis score keeper: detects the ball leaving either end of the court on the
// negative-true shift register and keeps point, game and match state.
module tennis_score_keeper #(
    parameter int unsigned GAMES_TO_WIN = 6
) (
    input logic                 CLK100MHZ,
    input logic                 reset,
    tennis_score_keeper_if.slave score_io
);

    logic [7:0] nl_q;
    logic       toss_q;
    logic [2:0] left_pts_q, left_pts_d;
    logic [2:0] right_pts_q, right_pts_d;
    logic [3:0] left_games_q, left_games_d;
    logic [3:0] right_games_q, right_games_d;
    logic       point_left_q, point_left_d;
    logic       point_right_q, point_right_d;
    logic       game_won_q, game_won_d;
    logic       match_over_q, match_over_d;

    logic       exit_left_end;   // ball gone past the left end: right player scores
    logic       exit_right_end;  // ball gone past the right end: left player scores
    logic       toss_rise;
    logic [2:0] s_pts, o_pts, s_pts_new, o_pts_new;
    logic [3:0] s_games, s_games_new;
    logic       game_win;

    assign exit_left_end  = (nl_q == 8'b0111_1111) && (score_io.nL == 8'hFF);
    assign exit_right_end = (nl_q == 8'b1111_1110) && (score_io.nL == 8'hFF);
    assign toss_rise      = !toss_q && score_io.toss;

    // State register with synchronous reset.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            nl_q          <= 8'hFF;
            toss_q        <= 1'b0;
            left_pts_q    <= 3'd0;
            right_pts_q   <= 3'd0;
            left_games_q  <= 4'd0;
            right_games_q <= 4'd0;
            point_left_q  <= 1'b0;
            point_right_q <= 1'b0;
            game_won_q    <= 1'b0;
            match_over_q  <= 1'b0;
        end else begin
            nl_q          <= score_io.nL;
            toss_q        <= score_io.toss;
            left_pts_q    <= left_pts_d;
            right_pts_q   <= right_pts_d;
            left_games_q  <= left_games_d;
            right_games_q <= right_games_d;
            point_left_q  <= point_left_d;
            point_right_q <= point_right_d;
            game_won_q    <= game_won_d;
            match_over_q  <= match_over_d;
        end
    end

    // Next-state: scorer/opponent view of the point ladder, then map back to left/right.
    always_comb begin
        s_pts       = exit_right_end ? left_pts_q : right_pts_q;
        o_pts       = exit_right_end ? right_pts_q : left_pts_q;
        s_games     = exit_right_end ? left_games_q : right_games_q;
        s_pts_new   = s_pts;
        o_pts_new   = o_pts;
        game_win    = 1'b0;
        if (s_pts < 3'd3) begin
            s_pts_new = s_pts + 3'd1;
        end else if (s_pts == 3'd3) begin
            if (o_pts <= 3'd2) begin
                game_win = 1'b1;
            end else if (o_pts == 3'd3) begin
                s_pts_new = 3'd4;
            end else begin
                o_pts_new = 3'd3;  // opponent loses advantage, back to deuce
            end
        end else begin
            game_win = 1'b1;
        end
        if (game_win) begin
            s_pts_new = 3'd0;
            o_pts_new = 3'd0;
        end
        s_games_new = game_win ? s_games + 4'd1 : s_games;

        left_pts_d    = left_pts_q;
        right_pts_d   = right_pts_q;
        left_games_d  = left_games_q;
        right_games_d = right_games_q;
        point_left_d  = 1'b0;
        point_right_d = 1'b0;
        game_won_d    = 1'b0;
        match_over_d  = match_over_q;

        if (match_over_q) begin
            // Exits are frozen out; only a toss edge restarts the match.
            if (toss_rise) begin
                left_pts_d    = 3'd0;
                right_pts_d   = 3'd0;
                left_games_d  = 4'd0;
                right_games_d = 4'd0;
                match_over_d  = 1'b0;
            end
        end else if (exit_right_end || exit_left_end) begin
            if (exit_right_end) begin
                left_pts_d   = s_pts_new;
                right_pts_d  = o_pts_new;
                left_games_d = s_games_new;
                point_left_d = 1'b1;
            end else begin
                right_pts_d   = s_pts_new;
                left_pts_d    = o_pts_new;
                right_games_d = s_games_new;
                point_right_d = 1'b1;
            end
            game_won_d   = game_win;
            match_over_d = game_win && (s_games_new == 4'(GAMES_TO_WIN));
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        score_io.left_pts    = left_pts_q;
        score_io.right_pts   = right_pts_q;
        score_io.left_games  = left_games_q;
        score_io.right_games = right_games_q;
        score_io.point_left  = point_left_q;
        score_io.point_right = point_right_q;
        score_io.game_won    = game_won_q;
        score_io.match_over  = match_over_q;
    end

endmodule

// File: tb/tb_tennis_score_keeper.sv
// Directed bench for the tennis score keeper, built with a two-game match.
module tb_tennis_score_keeper;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    tennis_score_keeper_if bus ();

    tennis_score_keeper #(.GAMES_TO_WIN(2)) dut (
        .CLK100MHZ (clk),
        .reset     (rst),
        .score_io  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst     = 1'b1;
        bus.nL   = 8'hFF;
        bus.toss = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Ball leaves past the left end: right player scores.
    task automatic exit_left;
        bus.nL = 8'b0111_1111;
        tick();
        bus.nL = 8'hFF;
        tick();
    endtask

    // Ball leaves past the right end: left player scores.
    task automatic exit_right;
        bus.nL = 8'b1111_1110;
        tick();
        bus.nL = 8'hFF;
        tick();
    endtask

    task automatic test_reset;
        bus.nL = 8'b0111_1111;
        do_reset();
        checks++;
        if ({bus.left_pts, bus.right_pts, bus.left_games, bus.right_games} !== 14'd0) begin
            errors++;
            $display("FAIL reset_scores: got %h want 0",
                     {bus.left_pts, bus.right_pts, bus.left_games, bus.right_games});
        end
        checks++;
        if ({bus.point_left, bus.point_right, bus.game_won, bus.match_over} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000",
                     {bus.point_left, bus.point_right, bus.game_won, bus.match_over});
        end
    endtask

    task automatic test_single_point;
        do_reset();
        exit_left();
        checks++;
        if ({bus.point_right, bus.point_left} !== 2'b10) begin
            errors++;
            $display("FAIL single_pulse: got %b want 10", {bus.point_right, bus.point_left});
        end
        checks++;
        if (bus.right_pts !== 3'd1 || bus.left_pts !== 3'd0) begin
            errors++;
            $display("FAIL single_pts: got r=%0d l=%0d want r=1 l=0", bus.right_pts, bus.left_pts);
        end
        tick();
        checks++;
        if (bus.point_right !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse_width: got %b want 0", bus.point_right);
        end
    endtask

    task automatic test_left_game;
        logic [2:0] exp_lp [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
        logic       exp_gw [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exit_right();
            checks++;
            if (bus.left_pts !== exp_lp[i] || bus.right_pts !== 3'd0) begin
                errors++;
                $display("FAIL left_game_pts[%0d]: got l=%0d r=%0d want l=%0d r=0",
                         i, bus.left_pts, bus.right_pts, exp_lp[i]);
            end
            checks++;
            if (bus.game_won !== exp_gw[i] || bus.point_left !== 1'b1) begin
                errors++;
                $display("FAIL left_game_pulse[%0d]: got gw=%b pl=%b want gw=%b pl=1",
                         i, bus.game_won, bus.point_left, exp_gw[i]);
            end
        end
        checks++;
        if (bus.left_games !== 4'd1 || bus.right_games !== 4'd0) begin
            errors++;
            $display("FAIL left_game_count: got l=%0d r=%0d want l=1 r=0",
                     bus.left_games, bus.right_games);
        end
    endtask

    task automatic test_deuce;
        // 1 = left scores (right-end exit), 0 = right scores
        logic       who    [10] = '{1, 1, 1, 0, 0, 0, 1, 0, 1, 1};
        logic [2:0] exp_lp [10] = '{1, 2, 3, 3, 3, 3, 4, 3, 4, 0};
        logic [2:0] exp_rp [10] = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 0};
        logic [3:0] exp_lg [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (who[i]) exit_right();
            else exit_left();
            checks++;
            if (bus.left_pts !== exp_lp[i] || bus.right_pts !== exp_rp[i] ||
                bus.left_games !== exp_lg[i]) begin
                errors++;
                $display("FAIL deuce[%0d]: got l=%0d r=%0d lg=%0d want l=%0d r=%0d lg=%0d",
                         i, bus.left_pts, bus.right_pts, bus.left_games,
                         exp_lp[i], exp_rp[i], exp_lg[i]);
            end
        end
        checks++;
        if (bus.game_won !== 1'b1) begin
            errors++;
            $display("FAIL deuce_game_won: got %b want 1", bus.game_won);
        end
    endtask

    task automatic test_match;
        logic [2:0] exp_rp [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
        logic [3:0] exp_rg [8] = '{0, 0, 0, 1, 1, 1, 1, 2};
        logic       exp_mo [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exit_left();
            checks++;
            if (bus.right_pts !== exp_rp[i] || bus.right_games !== exp_rg[i] ||
                bus.match_over !== exp_mo[i]) begin
                errors++;
                $display("FAIL match[%0d]: got rp=%0d rg=%0d mo=%b want rp=%0d rg=%0d mo=%b",
                         i, bus.right_pts, bus.right_games, bus.match_over,
                         exp_rp[i], exp_rg[i], exp_mo[i]);
            end
        end
        exit_right();
        checks++;
        if (bus.point_left !== 1'b0 || bus.left_pts !== 3'd0 || bus.right_games !== 4'd2 ||
            bus.match_over !== 1'b1) begin
            errors++;
            $display("FAIL match_frozen: got pl=%b lp=%0d rg=%0d mo=%b want pl=0 lp=0 rg=2 mo=1",
                     bus.point_left, bus.left_pts, bus.right_games, bus.match_over);
        end
        bus.toss = 1'b1;
        tick();
        checks++;
        if (bus.match_over !== 1'b0 || bus.right_games !== 4'd0 || bus.left_games !== 4'd0 ||
            bus.right_pts !== 3'd0) begin
            errors++;
            $display("FAIL match_restart: got mo=%b rg=%0d lg=%0d rp=%0d want all 0",
                     bus.match_over, bus.right_games, bus.left_games, bus.right_pts);
        end
        bus.toss = 1'b0;
        tick();
    endtask

    task automatic test_toss_ignored;
        do_reset();
        exit_right();
        bus.toss = 1'b1;
        tick();
        checks++;
        if (bus.left_pts !== 3'd1 || bus.match_over !== 1'b0) begin
            errors++;
            $display("FAIL toss_ignored: got lp=%0d mo=%b want lp=1 mo=0",
                     bus.left_pts, bus.match_over);
        end
        bus.toss = 1'b0;
        tick();
    endtask

    task automatic test_no_event;
        logic [7:0] seq [7] = '{8'hFF, 8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hFB, 8'hFF};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            bus.nL = seq[i];
            tick();
            checks++;
            if (bus.point_left !== 1'b0 || bus.point_right !== 1'b0 ||
                bus.left_pts !== 3'd0 || bus.right_pts !== 3'd0) begin
                errors++;
                $display("FAIL no_event[%0d]: got pl=%b pr=%b lp=%0d rp=%0d want 0",
                         i, bus.point_left, bus.point_right, bus.left_pts, bus.right_pts);
            end
        end
    endtask

    task automatic test_reset_with_exit;
        do_reset();
        exit_right();
        bus.nL = 8'b1111_1110;
        tick();
        bus.nL = 8'hFF;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.point_left !== 1'b0 || bus.left_pts !== 3'd0) begin
            errors++;
            $display("FAIL reset_with_exit: got pl=%b lp=%0d want pl=0 lp=0",
                     bus.point_left, bus.left_pts);
        end
        tick();
        checks++;
        if (bus.point_left !== 1'b0 || bus.left_pts !== 3'd0) begin
            errors++;
            $display("FAIL reset_with_exit_after: got pl=%b lp=%0d want pl=0 lp=0",
                     bus.point_left, bus.left_pts);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        exit_left();
        exit_right();
        checks++;
        if (bus.point_left !== 1'b1 || bus.point_right !== 1'b0 ||
            bus.left_pts !== 3'd1 || bus.right_pts !== 3'd1) begin
            errors++;
            $display("FAIL back_to_back: got pl=%b pr=%b lp=%0d rp=%0d want pl=1 pr=0 lp=1 rp=1",
                     bus.point_left, bus.point_right, bus.left_pts, bus.right_pts);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        bus.nL   = 8'hFF;
        bus.toss = 1'b0;
        test_reset();
        test_single_point();
        test_left_game();
        test_deuce();
        test_match();
        test_toss_ignored();
        test_no_event();
        test_reset_with_exit();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
